// File: rtl/fb_atomic_rmw.sv
// Warp-wide atomic read-modify-write unit: active lanes that hit the same 32-bit word
// are merged into one group, and each group costs exactly one memory read and one write.
module fb_atomic_rmw #(
   parameter int NUM_LANES = 32,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_LAT   = 2,
   parameter int CNT_W     = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic [NUM_LANES-1:0]          req_mask_i,
   input  logic [1:0]                    req_op_i,
   input  logic [NUM_LANES*ADDR_W-1:0]   req_addr_i,
   input  logic [NUM_LANES*DATA_W-1:0]   req_data_i,
   output logic                          mem_rd_en_o,
   output logic [ADDR_W-1:0]             mem_rd_addr_o,
   input  logic [DATA_W-1:0]             mem_rd_data_i,
   output logic                          mem_wr_en_o,
   output logic [ADDR_W-1:0]             mem_wr_addr_o,
   output logic [DATA_W-1:0]             mem_wr_data_o,
   output logic                          rsp_valid_o,
   input  logic                          rsp_ready_i,
   output logic [NUM_LANES*DATA_W-1:0]   rsp_old_o,
   output logic [CNT_W-1:0]              wr_count_o
);

   localparam int WA_W = ADDR_W - 2;
   localparam int WC_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_RD, S_WAIT, S_WR, S_DONE} state_e;

   state_e                           state_q, state_d;
   logic [NUM_LANES-1:0]             pend_q;
   logic [1:0]                       op_q;
   logic [NUM_LANES-1:0][WA_W-1:0]   waddr_q;
   logic [NUM_LANES-1:0][DATA_W-1:0] data_q, old_lane_q;
   logic [NUM_LANES-1:0]             grp_q, grp_c;
   logic [WA_W-1:0]                  lead_q, lead_c;
   logic [DATA_W-1:0]                comb_q, comb_c, old_q;
   logic [WC_W-1:0]                  wcnt_q;
   logic [CNT_W-1:0]                 wr_cnt_q;
   logic                             found_c;
   logic [NUM_LANES-1:0][WA_W-1:0]   lane_wa;
   logic [NUM_LANES-1:0][1:0]        lane_lo;
   logic                             unused_addr_lo;

   function automatic logic [DATA_W-1:0] f_op(input logic [1:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
      case (op)
         2'b00:   return a | b;
         2'b01:   return a & b;
         2'b10:   return a ^ b;
         default: return (a > b) ? a : b;
      endcase
   endfunction

   // Byte offset within the word never matters; only word addresses are kept.
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign lane_wa[g] = req_addr_i[g*ADDR_W+2 +: WA_W];
      assign lane_lo[g] = req_addr_i[g*ADDR_W +: 2];
   end
   assign unused_addr_lo = ^lane_lo;

   // Leader is the lowest pending lane; its group folds in ascending lane order.
   always_comb begin
      found_c = 1'b0;
      lead_c  = '0;
      grp_c   = '0;
      comb_c  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (pend_q[i] && !found_c) begin
            found_c = 1'b1;
            lead_c  = waddr_q[i];
         end
      end
      for (int i = 0; i < NUM_LANES; i++) begin
         if (pend_q[i] && waddr_q[i] == lead_c) begin
            comb_c   = (grp_c == '0) ? data_q[i] : f_op(op_q, comb_c, data_q[i]);
            grp_c[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (req_valid_i) state_d = (req_mask_i != '0) ? S_SCAN : S_DONE;
         S_SCAN: state_d = S_RD;
         S_RD:   state_d = S_WAIT;
         S_WAIT: if (wcnt_q == '0) state_d = S_WR;
         S_WR:   state_d = ((pend_q & ~grp_q) == '0) ? S_DONE : S_SCAN;
         S_DONE: if (rsp_ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready_o   = 1'b0;
      mem_rd_en_o   = 1'b0;
      mem_rd_addr_o = '0;
      mem_wr_en_o   = 1'b0;
      mem_wr_addr_o = '0;
      mem_wr_data_o = '0;
      rsp_valid_o   = 1'b0;
      case (state_q)
         S_IDLE: req_ready_o = 1'b1;
         S_RD: begin
            mem_rd_en_o   = 1'b1;
            mem_rd_addr_o = {lead_q, 2'b00};
         end
         S_WR: begin
            mem_wr_en_o   = 1'b1;
            mem_wr_addr_o = {lead_q, 2'b00};
            mem_wr_data_o = f_op(op_q, old_q, comb_q);
         end
         S_DONE: rsp_valid_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pend_q     <= '0;
         op_q       <= '0;
         waddr_q    <= '0;
         data_q     <= '0;
         old_lane_q <= '0;
         grp_q      <= '0;
         lead_q     <= '0;
         comb_q     <= '0;
         old_q      <= '0;
         wcnt_q     <= '0;
         wr_cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (req_valid_i) begin
               pend_q     <= req_mask_i;
               op_q       <= req_op_i;
               waddr_q    <= lane_wa;
               data_q     <= req_data_i;
               old_lane_q <= '0;
            end
            S_SCAN: begin
               grp_q  <= grp_c;
               lead_q <= lead_c;
               comb_q <= comb_c;
            end
            S_RD: wcnt_q <= WC_W'(MEM_LAT - 1);
            S_WAIT: begin
               wcnt_q <= wcnt_q - 1'b1;
               if (wcnt_q == '0) old_q <= mem_rd_data_i;
            end
            S_WR: begin
               pend_q <= pend_q & ~grp_q;
               for (int i = 0; i < NUM_LANES; i++)
                  if (grp_q[i]) old_lane_q[i] <= old_q;
               if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign rsp_old_o  = old_lane_q;
   assign wr_count_o = wr_cnt_q;

endmodule
